// File: rtl/rounding_sat_pipe.sv
// rounding_sat_pipe: per-channel field extract, rounding, saturate/wrap in
// two pipeline stages, plus per-channel sticky overflow and an event counter.
module rounding_sat_pipe #(
   parameter  int WIDTH     = 32,
   parameter  int START_BIT = 30,
   parameter  int END_BIT   = 16,
   parameter  int CHANNELS  = 2,
   parameter  int CNT_W     = 16,
   localparam int OW        = START_BIT - END_BIT + 1
) (
   input  logic                      clk,
   input  logic                      reset_b,
   input  logic                      valid_in,
   input  logic [CHANNELS*WIDTH-1:0] data_input,
   input  logic [1:0]                mode,
   input  logic                      sat_en,
   input  logic                      clr,
   output logic                      valid_out,
   output logic [CHANNELS*OW-1:0]    data_output,
   output logic [CHANNELS-1:0]       ovf_out,
   output logic [CHANNELS-1:0]       ovf_sticky,
   output logic [CNT_W-1:0]          sat_cnt
);
   localparam logic [OW-1:0] FMAX = {1'b0, {(OW-1){1'b1}}};
   localparam logic [OW-1:0] FMIN = {1'b1, {(OW-1){1'b0}}};

   logic [CHANNELS-1:0][OW-1:0] s1_f_d, s1_f_q, s2_res_d, data_q;
   logic [CHANNELS-1:0]         s1_inc_d, s1_inc_q;
   logic [CHANNELS-1:0]         s1_ovf_d, s1_ovf_q;
   logic [CHANNELS-1:0]         s1_s_d, s1_s_q;
   logic                        s1_sat_q, s1_v_q;
   logic                        valid_q;
   logic [CHANNELS-1:0]         ovf_q, sticky_q, sticky_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d, cnt_base;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [WIDTH-1:0] x;
      logic [OW-1:0]    f, sum;
      logic             h, l, s, inc, rng;

      assign x = data_input[c*WIDTH +: WIDTH];
      assign f = x[START_BIT:END_BIT];
      assign h = x[END_BIT-1];
      assign l = |x[END_BIT-2:0];
      assign s = x[WIDTH-1];

      always_comb begin
         unique case (mode)
            2'd0:    inc = 1'b0;
            2'd1:    inc = h & (~s | l);
            2'd2:    inc = h & (l | f[0]);
            default: inc = h;
         endcase
      end

      // Bits above the field must all match the sign for f to be exact.
      if (START_BIT < WIDTH-1) begin : g_rng
         logic [WIDTH-1-START_BIT:0] top;
         assign top = x[WIDTH-1:START_BIT];
         assign rng = ~((&top) | (~|top));
      end else begin : g_norng
         assign rng = 1'b0;
      end

      assign s1_f_d[c]   = f;
      assign s1_inc_d[c] = inc;
      assign s1_ovf_d[c] = rng | (inc & (f == FMAX));
      assign s1_s_d[c]   = s;

      assign sum = s1_f_q[c] + {{(OW-1){1'b0}}, s1_inc_q[c]};
      assign s2_res_d[c] = (s1_ovf_q[c] & s1_sat_q)
                         ? (s1_s_q[c] ? FMIN : FMAX) : sum;
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         s1_v_q   <= 1'b0;
         s1_f_q   <= '0;
         s1_inc_q <= '0;
         s1_ovf_q <= '0;
         s1_s_q   <= '0;
         s1_sat_q <= 1'b0;
      end else begin
         s1_v_q <= valid_in;
         if (valid_in) begin
            s1_f_q   <= s1_f_d;
            s1_inc_q <= s1_inc_d;
            s1_ovf_q <= s1_ovf_d;
            s1_s_q   <= s1_s_d;
            s1_sat_q <= sat_en;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ovf_q   <= '0;
      end else begin
         valid_q <= s1_v_q;
         if (s1_v_q) begin
            data_q <= s2_res_d;
            ovf_q  <= s1_ovf_q;
         end
      end
   end

   // A clear and a same-cycle event: clear first, then apply the event.
   always_comb begin
      sticky_d = (clr ? '0 : sticky_q) | (valid_q ? ovf_q : '0);
      cnt_base = clr ? '0 : cnt_q;
      cnt_d    = cnt_base;
      if (valid_q && (|ovf_q) && (cnt_base != '1))
         cnt_d = cnt_base + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         sticky_q <= '0;
         cnt_q    <= '0;
      end else begin
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

   assign valid_out   = valid_q;
   assign data_output = data_q;
   assign ovf_out     = ovf_q;
   assign ovf_sticky  = sticky_q;
   assign sat_cnt     = cnt_q;
endmodule

// File: tb/tb_rounding_sat_pipe.sv
// tb_rounding_sat_pipe: arithmetic reference model, per-cycle compare,
// directed literal cases and a randomized stream with gaps and reset.
module tb_rounding_sat_pipe;
   localparam int W  = 32;
   localparam int SB = 30;
   localparam int EB = 16;
   localparam int CH = 2;
   localparam int OW = SB - EB + 1;
   localparam int CW = 16;

   logic clk = 0, reset_b = 0, valid_in = 0, sat_en = 0, clr = 0;
   logic [1:0]      mode = 0;
   logic [CH*W-1:0] data_input = '0;

   logic             valid_out, valid_out2;
   logic [CH*OW-1:0] data_output, data_output2;
   logic [CH-1:0]    ovf_out, ovf_out2, ovf_sticky, ovf_sticky2;
   logic [CW-1:0]    sat_cnt;
   logic [1:0]       sat_cnt2;

   int nvec = 0, nerr = 0;

   always #5 clk = ~clk;

   rounding_sat_pipe #(.WIDTH(W), .START_BIT(SB), .END_BIT(EB),
                       .CHANNELS(CH), .CNT_W(CW)) dut (
      .clk(clk), .reset_b(reset_b), .valid_in(valid_in),
      .data_input(data_input), .mode(mode), .sat_en(sat_en), .clr(clr),
      .valid_out(valid_out), .data_output(data_output),
      .ovf_out(ovf_out), .ovf_sticky(ovf_sticky), .sat_cnt(sat_cnt));

   rounding_sat_pipe #(.WIDTH(W), .START_BIT(SB), .END_BIT(EB),
                       .CHANNELS(CH), .CNT_W(2)) u_sm (
      .clk(clk), .reset_b(reset_b), .valid_in(valid_in),
      .data_input(data_input), .mode(mode), .sat_en(sat_en), .clr(clr),
      .valid_out(valid_out2), .data_output(data_output2),
      .ovf_out(ovf_out2), .ovf_sticky(ovf_sticky2), .sat_cnt(sat_cnt2));

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Reference: real-valued rounding of x / 2^EB, then range test.
   function automatic void ref_ch(input logic [31:0] x, input logic [1:0] md,
                                  input logic se, output logic [OW-1:0] r,
                                  output logic o);
      longint v, fl, fr, q, one, half, maxv, minv;
      one  = longint'(1) <<< EB;
      half = one / 2;
      maxv = (longint'(1) <<< (OW-1)) - 1;
      minv = -(longint'(1) <<< (OW-1));
      v    = longint'($signed(x));
      fl   = v >>> EB;
      fr   = v - fl * one;
      q    = fl;
      case (md)
         2'd1: if (fr > half || (fr == half && v >= 0)) q = fl + 1;
         2'd2: if (fr > half || (fr == half && fl[0])) q = fl + 1;
         2'd3: if (fr >= half) q = fl + 1;
         default: q = fl;
      endcase
      o = (fl > maxv) || (fl < minv) || (q > maxv);
      if (o && se) r = (v < 0) ? {1'b1, {(OW-1){1'b0}}}
                               : {1'b0, {(OW-1){1'b1}}};
      else r = q[OW-1:0];
   endfunction

   function automatic void ref_vec(input logic [CH*W-1:0] din,
                                   input logic [1:0] md, input logic se,
                                   output logic [CH*OW-1:0] d,
                                   output logic [CH-1:0] o);
      logic [OW-1:0] r;
      logic          ov;
      for (int c = 0; c < CH; c++) begin
         ref_ch(din[c*W +: W], md, se, r, ov);
         d[c*OW +: OW] = r;
         o[c]          = ov;
      end
   endfunction

   logic             m1_v = 0, mo_v = 0;
   logic [CH*OW-1:0] m1_d = '0, mo_d = '0;
   logic [CH-1:0]    m1_o = '0, mo_o = '0, m_st = '0;
   int               m_cnt = 0, m_cnt2 = 0;

   initial forever begin
      @(posedge clk); #1;
      if (!reset_b) begin
         m1_v = 0; mo_v = 0; m1_d = '0; mo_d = '0;
         m1_o = '0; mo_o = '0; m_st = '0; m_cnt = 0; m_cnt2 = 0;
      end else begin
         if (clr) begin m_st = '0; m_cnt = 0; m_cnt2 = 0; end
         if (mo_v) begin
            m_st = m_st | mo_o;
            if (|mo_o) begin
               if (m_cnt < 65535) m_cnt++;
               if (m_cnt2 < 3) m_cnt2++;
            end
         end
         mo_v = m1_v;
         if (m1_v) begin mo_d = m1_d; mo_o = m1_o; end
         m1_v = valid_in;
         if (valid_in) ref_vec(data_input, mode, sat_en, m1_d, m1_o);
      end
      chk("out", {valid_out, ovf_out, data_output}, {mo_v, mo_o, mo_d});
      chk("status", {ovf_sticky, sat_cnt}, {m_st, m_cnt[15:0]});
      chk("cnt2", {ovf_sticky2, sat_cnt2}, {m_st, m_cnt2[1:0]});
   end

   task automatic vec(input logic [31:0] x0, input logic [31:0] x1,
                      input logic [1:0] md, input logic se,
                      input logic [OW-1:0] e0, input logic eo,
                      input string nm);
      @(negedge clk);
      valid_in = 1; data_input = {x1, x0}; mode = md; sat_en = se;
      @(negedge clk);
      valid_in = 0; mode = ~md; sat_en = ~se;
      chk({nm, "_lat"}, valid_out, 1'b0);
      @(posedge clk); #1;
      chk({nm, "_v"}, valid_out, 1'b1);
      chk({nm, "_d"}, data_output[OW-1:0], e0);
      chk({nm, "_o"}, ovf_out[0], eo);
   endtask

   function automatic logic [31:0] rnd_x();
      logic [31:0] x;
      x = $urandom;
      case ($urandom_range(0, 3))
         1: x[31:30] = {2{x[29]}};
         2: x[31:16] = 16'h3FFF;
         3: begin x[15:0] = 16'h8000; x[31:30] = {2{x[29]}}; end
         default: ;
      endcase
      return x;
   endfunction

   logic [OW-1:0] hp[4] = '{15'h0000, 15'h0001, 15'h0000, 15'h0001};
   logic [OW-1:0] nh[4] = '{15'h7FFF, 15'h7FFF, 15'h0000, 15'h0000};
   logic [OW-1:0] pr;
   logic          po;
   int            applied;

   initial begin
      ref_ch(32'h0000_8000, 2'd1, 1'b1, pr, po);
      chk("pin_half", {po, pr}, {1'b0, 15'h0001});
      ref_ch(32'hFFFF_8000, 2'd2, 1'b1, pr, po);
      chk("pin_neg", {po, pr}, {1'b0, 15'h0000});
      ref_ch(32'h3FFF_C000, 2'd1, 1'b0, pr, po);
      chk("pin_incw", {po, pr}, {1'b1, 15'h4000});
      ref_ch(32'h8000_0000, 2'd0, 1'b1, pr, po);
      chk("pin_rng", {po, pr}, {1'b1, 15'h4000});

      repeat (3) @(negedge clk);
      reset_b = 1;
      chk("rst", {valid_out, ovf_out, data_output, ovf_sticky, sat_cnt}, '0);

      for (int m = 0; m < 4; m++)
         vec(32'h0000_8000, 0, 2'(m), 1, hp[m], 0, $sformatf("half%0d", m));
      for (int m = 0; m < 4; m++)
         vec(32'hFFFF_8000, 0, 2'(m), 1, nh[m], 0, $sformatf("nhalf%0d", m));
      vec(32'h0001_8000, 0, 2'd2, 1, 15'h0002, 0, "conv15");
      vec(32'h3FFF_C000, 0, 2'd1, 1, 15'h3FFF, 1, "incsat");
      vec(32'h3FFF_C000, 0, 2'd1, 0, 15'h4000, 1, "incwrap");
      vec(32'h4000_0000, 32'h0002_0000, 2'd0, 1, 15'h3FFF, 1, "rngpos");
      vec(32'h8000_0000, 32'h0002_0000, 2'd0, 1, 15'h4000, 1, "rngneg");
      chk("ch1_d", data_output[2*OW-1:OW], 15'h0002);
      chk("ch1_o", ovf_out[1], 1'b0);
      @(posedge clk); #1;
      chk("sticky", ovf_sticky, 2'b01);
      chk("cnt4", sat_cnt, 16'd4);
      chk("cnt2_hold", sat_cnt2, 2'd3);

      @(negedge clk); clr = 1;
      @(negedge clk); clr = 0;
      for (int i = 0; i < 3; i++)
         vec(32'h4000_0000, 0, 2'd0, 1, 15'h3FFF, 1, "ovf3");
      @(posedge clk); #1;
      chk("cnt3", sat_cnt, 16'd3);
      vec(32'h4000_0000, 0, 2'd0, 1, 15'h3FFF, 1, "ovfclr");
      @(negedge clk); clr = 1;
      @(posedge clk); #1;
      chk("clr_cnt", sat_cnt, 16'd1);
      chk("clr_sticky", ovf_sticky, 2'b01);
      chk("clr_cnt2", sat_cnt2, 2'd1);
      @(negedge clk); clr = 0;

      applied = 0;
      while (applied < 1000) begin
         @(negedge clk);
         valid_in   = ($urandom_range(0, 3) != 0);
         data_input = {rnd_x(), rnd_x()};
         mode       = 2'($urandom_range(0, 3));
         sat_en     = 1'($urandom_range(0, 1));
         clr        = ($urandom_range(0, 49) == 0);
         if (valid_in) applied++;
      end
      @(negedge clk);
      valid_in = 0; clr = 0;
      repeat (3) @(negedge clk);

      valid_in = 1; data_input = {rnd_x(), 32'h4000_0000};
      @(negedge clk);
      data_input = {rnd_x(), 32'h8000_0000};
      @(posedge clk); #2;
      reset_b = 0; valid_in = 0;
      #1;
      chk("rst_async",
          {valid_out, ovf_out, data_output, ovf_sticky, sat_cnt}, '0);
      repeat (2) @(negedge clk);
      reset_b = 1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #2;
         chk("rst_flush", valid_out, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/rounding_sat_pipe.md
# rounding_sat_pipe

Multi-channel, two-stage pipelined rounding and saturation block for two's-complement sample streams. Per channel, it extracts bit field [START_BIT:END_BIT] from a wide accumulator word and applies a runtime-selectable rounding mode. It then either saturates or wraps the result. Overflow is reported per sample, as a sticky flag per channel, and as an event counter. It sits after filter and NCO accumulators in the DSP chain, in front of narrower datapaths and the DAC/AFE interface.

## Interface
- WIDTH, 32, input word width per channel.
- START_BIT, 30, MSB of the output field. Legal range: END_BIT < START_BIT ≤ WIDTH-1.
- END_BIT, 16, LSB of the output field. END_BIT ≥ 2.
- CHANNELS, 2, number of parallel channels. All channels share valid, mode and control.
- CNT_W, 16, width of the saturation event counter.
- Derived: OW = START_BIT-END_BIT+1.

Ports:
- clk  in  1  clock.
- reset_b  in  1  reset; asynchronous, active-low.
- valid_in  in  1  data_input qualifier.
- data_input  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- mode  in  2  rounding mode. Sampled with valid_in.
- sat_en  in  1  1 = clamp, 0 = wrap. Sampled with valid_in.
- clr  in  1  synchronous clear of ovf_sticky and sat_cnt.
- valid_out  out  1  data_output qualifier.
- data_output  out  CHANNELS*OW  channel c occupies bits [c*OW +: OW].
- ovf_out  out  CHANNELS  per-sample overflow, aligned with valid_out.
- ovf_sticky  out  CHANNELS  per-channel sticky overflow.
- sat_cnt  out  CNT_W  number of output samples with any channel overflowed. Saturates at all-ones.

## Operation
Definitions per channel:
- x = input word.
- f = x[START_BIT:END_BIT].
- h = x[END_BIT-1], the half bit.
- l = |x[END_BIT-2:0], the remainder below the half bit.
- s = x[WIDTH-1], the sign.

Increment inc by mode:
- 0 truncate (floor): inc = 0.
- 1 round half away from zero: inc = h & (~s | l).
- 2 convergent (round half to even): inc = h & (l | f[0]).
- 3 round half up (toward +inf): inc = h.

Overflow:
- Range overflow: bits x[WIDTH-1:START_BIT] are not all equal. This term is absent when START_BIT = WIDTH-1.
- Increment overflow: inc=1 and f = 2^(OW-1)-1.
- ovf = range overflow OR increment overflow.

Result:
- ovf=0: f+inc, OW bits.
- ovf=1 with sat_en=1: s=0 gives 0 followed by ones (max). s=1 gives 1 followed by zeros (min).
- ovf=1 with sat_en=0: low OW bits of f+inc (wrap).

Pipeline:
- Stage 1 registers f, inc, ovf-class, s and sat_en per channel, plus valid.
- Stage 2 computes the add and the saturation mux, then registers data_output, ovf_out and valid_out.
- mode and sat_en travel with their sample. Changing them never affects samples already in flight.
- Stages advance only when their valid is high. With valid low, data_output and ovf_out hold their last value and valid_out=0.

Status:
- ovf_sticky[c] sets when valid_out=1 and ovf_out[c]=1.
- sat_cnt increments when valid_out=1 and |ovf_out. It holds at 2^CNT_W-1.
- clr zeroes ovf_sticky and sat_cnt. If an event occurs in the same cycle as clr, the event is applied after the clear, giving sticky=1 and sat_cnt=1.

Reset: all outputs and pipeline registers go to 0 asynchronously. Samples in flight are discarded; no valid_out is issued for them after release.

## Timing
- Latency is exactly 2 clk from valid_in to valid_out.
- Throughput is one sample vector per clk. There is no backpressure.
- Back-to-back valids produce back-to-back valid_out, in order.
- The first valid_out can occur at the 2nd rising edge after the first sampled valid_in following reset release.
- Status outputs update on the edge after valid_out=1, i.e. 1 clk after the data.

## Test plan
Defaults apply (OW=15), channel 0 unless stated.
- Half-point, x=0x0000_8000 (+0.5 LSB), sat_en=1: mode 0/1/2/3 yields 0x0000/0x0001/0x0000/0x0001, ovf_out=0, each 2 clk after valid_in.
- Negative half, x=0xFFFF_8000 (-0.5): mode 0/1/2/3 yields 0x7FFF/0x7FFF/0x0000/0x0000. For convergent, x=0x0001_8000 (1.5) in mode 2 yields 0x0002.
- Increment overflow, x=0x3FFF_C000, mode 1: sat_en=1 yields 0x3FFF with ovf_out=1; sat_en=0 yields 0x4000 with ovf_out=1.
- Range overflow: x=0x4000_0000 gives 0x3FFF; x=0x8000_0000 gives 0x4000. Channel 1 at the same time with x=0x0002_0000 gives 0x0002, ovf_out[1]=0, ovf_sticky=2'b01.
- Status: three overflowing vectors give sat_cnt=3. Then clr coinciding with an overflowing valid_out gives sat_cnt=1 and sticky=1. Bench with CNT_W=2: counter holds at 3.
- Streaming and reset:
  - Random 1000-vector stream with random valid gaps, per-sample mode and sat_en: outputs match the reference model, order is preserved, and gaps do not change held outputs.
  - reset_b asserted with 2 samples in flight: all outputs go to 0 immediately, and no valid_out appears after release.
